// File: rtl/bn_act_stream.sv
// Streaming fixed-point batch-norm + activation: y = act(sat((a*x + b [+rnd]) >>> R_SHIFT)).
// PAR lanes per beat; NO_GRP channel groups share the lanes in time, with per-group coefficients.
module bn_lane #(
    parameter int BW_IN   = 16,
    parameter int BW_A    = 16,
    parameter int BW_B    = 24,
    parameter int BW_OUT  = 16,
    parameter int R_SHIFT = 8,
    parameter int ROUND   = 0,
    parameter int MAXVAL  = 32767
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [BW_IN-1:0]  x,
    input  logic signed [BW_A-1:0]   a,
    input  logic signed [BW_B-1:0]   b,
    input  logic [1:0]               mode3,
    output logic signed [BW_OUT-1:0] y
);
    localparam int PW    = BW_IN + BW_A;
    localparam int SW    = PW + 1;
    localparam int QMAXI = 2**(BW_OUT-1) - 1;
    localparam int QMINI = -(2**(BW_OUT-1));
    localparam logic signed [SW-1:0]     RND  = (ROUND != 0) ? SW'(2**(R_SHIFT-1)) : '0;
    localparam logic signed [SW-1:0]     QMAX = SW'(QMAXI);
    localparam logic signed [SW-1:0]     QMIN = SW'(QMINI);
    localparam logic signed [SW-1:0]     QCAP = SW'(MAXVAL);
    localparam logic signed [BW_OUT-1:0] YMAX = BW_OUT'(QMAXI);
    localparam logic signed [BW_OUT-1:0] YMIN = BW_OUT'(QMINI);
    localparam logic signed [BW_OUT-1:0] YCAP = BW_OUT'(MAXVAL);

    logic signed [PW-1:0]     p;
    logic signed [BW_B-1:0]   b1;
    logic signed [SW-1:0]     s, q_c;
    logic signed [BW_OUT-1:0] q3, y_c;
    logic                     neg, hi, lo, gtmax;

    assign q_c = s >>> R_SHIFT;

    // Saturation decided in S3 from the full-width q, so S4 only muxes.
    always_comb begin
        y_c = q3;
        case (mode3)
            2'd0: begin
                if (hi)      y_c = YMAX;
                else if (lo) y_c = YMIN;
            end
            2'd2: begin
                if (neg)        y_c = '0;
                else if (gtmax) y_c = YCAP;
            end
            default: begin
                if (neg)     y_c = '0;
                else if (hi) y_c = YMAX;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p     <= '0;
            b1    <= '0;
            s     <= '0;
            q3    <= '0;
            neg   <= 1'b0;
            hi    <= 1'b0;
            lo    <= 1'b0;
            gtmax <= 1'b0;
            y     <= '0;
        end else if (en) begin
            p     <= PW'(x) * PW'(a);
            b1    <= b;
            s     <= SW'(p) + SW'(b1) + RND;
            q3    <= q_c[BW_OUT-1:0];
            neg   <= q_c[SW-1];
            hi    <= q_c > QMAX;
            lo    <= q_c < QMIN;
            gtmax <= q_c > QCAP;
            y     <= y_c;
        end
    end
endmodule

module bn_act_stream #(
    parameter int NO_CH   = 64,
    parameter int PAR     = 4,
    parameter int BW_IN   = 16,
    parameter int BW_A    = 16,
    parameter int BW_B    = 24,
    parameter int BW_OUT  = 16,
    parameter int R_SHIFT = 8,
    parameter int ROUND   = 0,
    parameter int MAXVAL  = 32767,
    localparam int NO_GRP = NO_CH / PAR,
    localparam int GW     = (NO_GRP > 1) ? $clog2(NO_GRP) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  coef_we,
    input  logic [GW-1:0]         coef_addr,
    input  logic [PAR*BW_A-1:0]   coef_a,
    input  logic [PAR*BW_B-1:0]   coef_b,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [PAR*BW_IN-1:0]  in_data,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [PAR*BW_OUT-1:0] out_data,
    output logic [GW-1:0]         out_grp,
    output logic                  out_last
);
    logic [NO_GRP-1:0][PAR*BW_A-1:0] mem_a;
    logic [NO_GRP-1:0][PAR*BW_B-1:0] mem_b;
    logic          en, acc;
    logic [4:1]    vld_pipe;
    logic [GW-1:0] grp, g1, g2, g3;
    logic [1:0]    m1, m2, m3;

    // One global enable: the whole pipe holds whenever the output is blocked.
    assign en      = out_rdy | ~out_vld;
    assign in_rdy  = en & rst_n;
    assign acc     = in_vld & in_rdy;
    assign out_vld = vld_pipe[4];

    // Not reset; the combinational read means a same-edge write is seen only by later beats.
    always_ff @(posedge clk) begin
        if (coef_we) begin
            mem_a[coef_addr] <= coef_a;
            mem_b[coef_addr] <= coef_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            grp      <= '0;
            g1       <= '0;
            g2       <= '0;
            g3       <= '0;
            m1       <= '0;
            m2       <= '0;
            m3       <= '0;
            out_grp  <= '0;
            out_last <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[3:1], acc};
            m1       <= mode;
            m2       <= m1;
            m3       <= m2;
            g1       <= grp;
            g2       <= g1;
            g3       <= g2;
            out_grp  <= g3;
            out_last <= (g3 == GW'(NO_GRP-1));
            if (acc) grp <= (grp == GW'(NO_GRP-1)) ? '0 : grp + 1'b1;
        end
    end

    for (genvar j = 0; j < PAR; j++) begin : g_lane
        bn_lane #(
            .BW_IN(BW_IN), .BW_A(BW_A), .BW_B(BW_B), .BW_OUT(BW_OUT),
            .R_SHIFT(R_SHIFT), .ROUND(ROUND), .MAXVAL(MAXVAL)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .x     (in_data[j*BW_IN +: BW_IN]),
            .a     (mem_a[grp][j*BW_A +: BW_A]),
            .b     (mem_b[grp][j*BW_B +: BW_B]),
            .mode3 (m3),
            .y     (out_data[j*BW_OUT +: BW_OUT])
        );
    end
endmodule

// File: tb/tb_bn_act_stream.sv
// Bench for bn_act_stream: truncating and rounding instances side by side, checked against
// an arithmetic reference model and a FIFO scoreboard of accepted beats.
module tb_bn_act_stream;
    logic        clk, rst_n, coef_we, in_vld, out_rdy;
    logic [1:0]  mode;
    logic [0:0]  coef_addr;
    logic [15:0] coef_a, in_data;
    logic [23:0] coef_b;
    logic        in_rdy0, out_vld0, out_last0, in_rdy1, out_vld1, out_last1;
    logic [15:0] out_data0, out_data1;
    logic [0:0]  out_grp0, out_grp1;

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        int          grp;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] outs[$];
    int ma[2][2], mb[2][2];
    int gcnt, cyc, acc_cyc, fire_cyc, nacc, nfire, n_cmp, n_err;

    bn_act_stream #(.NO_CH(4), .PAR(2), .BW_IN(8), .BW_A(8), .BW_B(12), .BW_OUT(8),
                    .R_SHIFT(4), .ROUND(0), .MAXVAL(100)) dut0 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_a(coef_a), .coef_b(coef_b), .in_vld(in_vld), .in_rdy(in_rdy0), .in_data(in_data),
        .out_vld(out_vld0), .out_rdy(out_rdy), .out_data(out_data0), .out_grp(out_grp0),
        .out_last(out_last0));

    bn_act_stream #(.NO_CH(4), .PAR(2), .BW_IN(8), .BW_A(8), .BW_B(12), .BW_OUT(8),
                    .R_SHIFT(4), .ROUND(1), .MAXVAL(100)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_a(coef_a), .coef_b(coef_b), .in_vld(in_vld), .in_rdy(in_rdy1), .in_data(in_data),
        .out_vld(out_vld1), .out_rdy(out_rdy), .out_data(out_data1), .out_grp(out_grp1),
        .out_last(out_last1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // y = act(sat(floor((a*x + b + rnd) / 16))) with the 8-bit output range.
    function automatic int model(input int x, input int a, input int b, input int md, input int rnd);
        int s, q;
        s = a * x + b + (rnd != 0 ? 8 : 0);
        q = (s >= 0) ? s / 16 : -((-s + 15) / 16);
        if (md == 0) begin
            if (q > 127) q = 127;
            if (q < -128) q = -128;
        end else begin
            if (q < 0) q = 0;
            if (md == 2 && q > 100) q = 100;
            if (md != 2 && q > 127) q = 127;
        end
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        exp_t        e;
        logic [15:0] d0, d1;
        int          xj;
        #1;
        if (out_vld0 && out_rdy) begin
            if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("data_trunc", out_data0, e.d0);
                chk("data_round", out_data1, e.d1);
                chk("grp", out_grp0, e.grp);
                chk("last", out_last0, (e.grp == 1));
                outs.push_back(out_data0);
                fire_cyc = cyc;
                nfire++;
            end
        end
        if (in_vld && in_rdy0) begin
            for (int j = 0; j < 2; j++) begin
                xj = $signed(in_data[j*8 +: 8]);
                d0[j*8 +: 8] = 8'(model(xj, ma[gcnt][j], mb[gcnt][j], mode, 0));
                d1[j*8 +: 8] = 8'(model(xj, ma[gcnt][j], mb[gcnt][j], mode, 1));
            end
            e.d0 = d0; e.d1 = d1; e.grp = gcnt;
            sb.push_back(e);
            gcnt = (gcnt + 1) % 2;
            acc_cyc = cyc;
            nacc++;
        end
        if (coef_we) begin
            for (int j = 0; j < 2; j++) begin
                ma[coef_addr][j] = $signed(coef_a[j*8 +: 8]);
                mb[coef_addr][j] = $signed(coef_b[j*12 +: 12]);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wcoef(input int g, input int a0, input int a1, input int b0, input int b1);
        coef_we = 1'b1; coef_addr = 1'(g);
        coef_a = {8'(a1), 8'(a0)}; coef_b = {12'(b1), 12'(b0)};
        tick();
        coef_we = 1'b0;
    endtask

    task automatic beat(input int x0, input int x1, input int md);
        in_vld = 1'b1; in_data = {8'(x1), 8'(x0)}; mode = 2'(md);
        tick();
        in_vld = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() > 0; k++) tick();
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int f0, a0, xi;
        n_cmp = 0; n_err = 0; cyc = 0; nacc = 0; nfire = 0; gcnt = 0;
        acc_cyc = 0; fire_cyc = 0;
        rst_n = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_a = '0; coef_b = '0;
        in_vld = 1'b0; in_data = '0; mode = '0; out_rdy = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rst_out_vld", out_vld0, 0);
        chk("rst_in_rdy", in_rdy0, 0);
        chk("rst_out_data", out_data0, 0);
        chk("rst_out_grp", out_grp0, 0);
        chk("rst_out_last", out_last0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Arithmetic and rounding; latency counted from accept cycle to first out_vld cycle.
        wcoef(0, 3, 3, -20, -20);
        wcoef(1, 3, 3, -20, -20);
        f0 = nfire;
        beat(10, -10, 0);
        for (int k = 0; k < 10 && nfire == f0; k++) tick();
        chk("t1_latency", fire_cyc - acc_cyc, 4);
        chk("t1_trunc", out_data0, 16'hFC00);
        chk("t1_round", out_data1, 16'hFD01);

        // Saturation and activation modes.
        wcoef(0, 64, 64, 0, 0);
        wcoef(1, 64, 64, 0, 0);
        beat(100, -100, 0); drain(); chk("t2_mode0", outs[$], 16'h807F);
        beat(100, -100, 1); drain(); chk("t2_mode1", outs[$], 16'h007F);
        beat(100, -100, 2); drain(); chk("t2_mode2", outs[$], 16'h0064);
        beat(100, -100, 3); drain(); chk("t2_mode3", outs[$], 16'h007F);
        beat(1, -1, 1);     drain(); chk("t2_small", outs[$], 16'h0004);

        // Framing: six back-to-back beats from group 0.
        if (gcnt != 0) beat(0, 0, 0);
        drain();
        outs.delete();
        for (int k = 0; k < 6; k++) begin
            in_vld = 1'b1; in_data = {8'(k), 8'(k * 3)}; mode = 2'd0;
            tick();
        end
        in_vld = 1'b0;
        drain();
        chk("t4_count", outs.size(), 6);

        // Backpressure: stall the output for six cycles with input still offered.
        xi = 0; f0 = nfire; a0 = nacc;
        in_vld = 1'b1; mode = 2'd1;
        for (int k = 0; k < 20 && !out_vld0; k++) begin
            in_data = {8'(xi + 1), 8'(xi)}; xi++;
            tick();
        end
        chk("t3_vld_seen", out_vld0, 1);
        out_rdy = 1'b0;
        outs.push_back(out_data0);
        for (int k = 0; k < 6; k++) begin
            in_data = {8'(xi + 1), 8'(xi)}; xi++;
            #1;
            chk("t3_in_rdy", in_rdy0, 0);
            chk("t3_hold_vld", out_vld0, 1);
            chk("t3_hold_data", out_data0, outs[$]);
            tick();
        end
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = {8'(xi + 1), 8'(xi)}; xi++;
            tick();
        end
        in_vld = 1'b0;
        drain();
        chk("t3_no_loss", nfire - f0, nacc - a0);

        // Coefficient write racing a group-1 beat: that beat keeps the old scale.
        wcoef(0, 1, 1, 0, 0);
        wcoef(1, 1, 1, 0, 0);
        if (gcnt != 0) beat(0, 0, 0);
        drain();
        outs.delete();
        beat(8, 8, 0);
        in_vld = 1'b1; in_data = {8'd8, 8'd8}; mode = 2'd0;
        coef_we = 1'b1; coef_addr = 1'b1; coef_a = {8'd2, 8'd2}; coef_b = '0;
        tick();
        coef_we = 1'b0; in_vld = 1'b0;
        beat(8, 8, 0);
        beat(8, 8, 0);
        drain();
        chk("t5_old_coef", outs[1], 16'h0000);
        chk("t5_new_coef", outs[3], 16'h0101);

        // Reset mid-frame with the output valid and three beats behind it.
        for (int k = 0; k < 4; k++) beat(k, -k, 0);
        #1;
        chk("t6_pre_vld", out_vld0, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", out_vld0, 0);
        chk("t6_rst_rdy", in_rdy0, 0);
        chk("t6_rst_data", out_data0, 0);
        sb.delete(); gcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        outs.delete();
        beat(32, -32, 0);
        drain();
        chk("t6_retained", outs[$], 16'hFE02);

        // Random traffic: random data, modes, coefficients, writes and backpressure.
        wcoef(0, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
              $urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);
        wcoef(1, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
              $urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);
        f0 = nfire; a0 = nacc;
        for (int k = 0; k < 400; k++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 3) != 0);
            in_data = 16'($urandom);
            mode    = 2'($urandom_range(0, 3));
            coef_we = ($urandom_range(0, 15) == 0);
            coef_addr = 1'($urandom_range(0, 1));
            coef_a  = 16'($urandom);
            coef_b  = 24'($urandom);
            tick();
        end
        in_vld = 1'b0; coef_we = 1'b0; out_rdy = 1'b1;
        drain();
        chk("rnd_count", nfire - f0, nacc - a0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
